psg_voice_mixer: RTL and testbench

Parametrised, pipelined waveform combiner and voice mixer for the PSG audio path.
- Per voice: combines up to NWAVE selected waveform generator outputs with a selectable logic mode (SID-style AND plus OR, XOR and MAX).
- Per frame: accumulates the combined result of up to NVOICE serially presented voices into one mixed sample, delivered over a valid/ready handshake.
- Placement: between the per-voice waveform generators and the envelope/DAC output stage.

---
 rtl/psg_voice_mixer.sv | 130 +++++++++++++
 tb/tb_psg_voice_mixer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/psg_voice_mixer.sv
// Waveform combiner and per-frame voice mixer: stage 1 combines selected waveforms,
// stage 2 accumulates voices into one sample. Define PSG_MIX_SCALE_EN to scale the sum by NVOICE.
module psg_voice_mixer #(
    parameter int WID    = 12,
    parameter int NWAVE  = 5,
    parameter int NVOICE = 4,
    parameter int ACCW   = WID + $clog2(NVOICE)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       vld_i,
    input  logic                       last_i,
    input  logic [NWAVE-1:0]           sel_i,
    input  logic [1:0]                 mode_i,
    input  logic [NWAVE*WID-1:0]       wave_i,
    output logic                       out_vld_o,
    input  logic                       out_rdy_i,
    output logic [ACCW-1:0]            sample_o,
    output logic [$clog2(NVOICE):0]    nvoc_o,
    output logic                       ovf_o
);
    localparam int LG = $clog2(NVOICE);
    localparam int CW = LG + 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    logic [NWAVE-1:0][WID-1:0] wv;
    logic [NWAVE-1:0][WID-1:0] frc;
    logic [WID-1:0]            c_and, c_or, c_xor, c_max, comb_val;

    logic           s1_vld, s1_last;
    logic [WID-1:0] s1_val;

    state_t          state_q, state_d;
    logic [CW-1:0]   vcnt;
    logic [ACCW-1:0] acc, acc_base, sum, scaled;
    logic            frame_end;

    assign wv = wave_i;

    // Unselected inputs become the identity of the active mode: ones for AND, zeros otherwise.
    genvar k;
    generate
        for (k = 0; k < NWAVE; k++) begin : g_force
            assign frc[k] = sel_i[k] ? wv[k] : {WID{mode_i == 2'b00}};
        end
    endgenerate

    always_comb begin
        c_and = '1;
        c_or  = '0;
        c_xor = '0;
        c_max = '0;
        for (int i = 0; i < NWAVE; i++) begin
            c_and = c_and & frc[i];
            c_or  = c_or  | frc[i];
            c_xor = c_xor ^ frc[i];
            if (sel_i[i] && wv[i] > c_max) c_max = wv[i];
        end
        case (mode_i)
            2'b00:   comb_val = c_and;
            2'b01:   comb_val = c_or;
            2'b10:   comb_val = c_xor;
            default: comb_val = c_max;
        endcase
        if (sel_i == '0) comb_val = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_val  <= '0;
        end else begin
            s1_vld  <= vld_i;
            s1_last <= vld_i & last_i;
            if (vld_i) s1_val <= comb_val;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_base  = (state_q == IDLE) ? '0 : acc;
        sum       = acc_base + ACCW'(s1_val);
        frame_end = s1_vld && (s1_last || vcnt == CW'(NVOICE - 1));
        if (s1_vld) state_d = frame_end ? IDLE : ACCUM;
    end

`ifdef PSG_MIX_SCALE_EN
    assign scaled = sum >> LG;
`else
    assign scaled = sum;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            acc     <= '0;
            vcnt    <= '0;
        end else begin
            state_q <= state_d;
            if (frame_end) begin
                acc  <= '0;
                vcnt <= '0;
            end else if (s1_vld) begin
                acc  <= sum;
                vcnt <= vcnt + CW'(1);
            end
        end
    end

    // A new frame always wins the output register; losing an unread one is an overrun.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_vld_o <= 1'b0;
            sample_o  <= '0;
            nvoc_o    <= '0;
            ovf_o     <= 1'b0;
        end else begin
            if (frame_end) begin
                out_vld_o <= 1'b1;
                sample_o  <= scaled;
                nvoc_o    <= vcnt + CW'(1);
                if (out_vld_o && !out_rdy_i) ovf_o <= 1'b1;
            end else if (out_rdy_i) begin
                out_vld_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_psg_voice_mixer.sv
// Scoreboard bench for psg_voice_mixer: stimulus pushes expected frames, a monitor pops on handshake.
module tb_psg_voice_mixer;
    logic        clk_i = 1'b0;
    logic        rst_i, vld_i, last_i, out_rdy_i;
    logic [4:0]  sel_i;
    logic [1:0]  mode_i;
    logic [59:0] wave_i;
    logic        out_vld_o, ovf_o;
    logic [13:0] sample_o;
    logic [2:0]  nvoc_o;

    int nvec = 0;
    int nerr = 0;
    logic [13:0] exp_s[$];
    logic [2:0]  exp_n[$];

    psg_voice_mixer dut (
        .clk_i(clk_i), .rst_i(rst_i), .vld_i(vld_i), .last_i(last_i),
        .sel_i(sel_i), .mode_i(mode_i), .wave_i(wave_i),
        .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
        .sample_o(sample_o), .nvoc_o(nvoc_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [13:0] scale(input logic [13:0] x);
`ifdef PSG_MIX_SCALE_EN
        return x >> 2;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [13:0] s, input logic [2:0] n);
        exp_s.push_back(s);
        exp_n.push_back(n);
    endtask

    task automatic send(input logic [4:0] s, input logic [1:0] m,
                        input logic [11:0] w0, w1, w2, w3, w4, input logic l);
        vld_i  = 1'b1;
        last_i = l;
        sel_i  = s;
        mode_i = m;
        wave_i = {w4, w3, w2, w1, w0};
        tick();
        vld_i  = 1'b0;
        last_i = 1'b0;
    endtask

    // Reference combine written per mode over the selected set only.
    function automatic logic [11:0] ref_comb(input logic [4:0] s, input logic [1:0] m,
                                             input logic [11:0] w[5]);
        logic [11:0] r;
        if (s == 5'd0) return 12'd0;
        r = (m == 2'b00) ? 12'hFFF : 12'h000;
        for (int i = 0; i < 5; i++) begin
            if (s[i]) begin
                case (m)
                    2'b00: r = r & w[i];
                    2'b01: r = r | w[i];
                    2'b10: r = r ^ w[i];
                    default: if (w[i] > r) r = w[i];
                endcase
            end
        end
        return r;
    endfunction

    always @(negedge clk_i) begin
        if (!rst_i && out_vld_o && out_rdy_i) begin
            if (exp_s.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_out: got sample 0x%0h nvoc %0d, expected none", sample_o, nvoc_o);
            end else begin
                chk("sample", sample_o, exp_s.pop_front());
                chk("nvoc", nvoc_o, exp_n.pop_front());
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1);
    end

    initial begin
        logic [11:0] w[5];
        logic [4:0]  rs;
        logic [1:0]  rm;
        logic        rl;
        logic [13:0] acc_m;
        int          cnt_m;

        rst_i = 1'b1; vld_i = 1'b0; last_i = 1'b0; out_rdy_i = 1'b0;
        sel_i = '0; mode_i = '0; wave_i = '0;
        repeat (3) tick();
        chk("rst_vld", out_vld_o, 0);
        chk("rst_sample", sample_o, 0);
        chk("rst_nvoc", nvoc_o, 0);
        chk("rst_ovf", ovf_o, 0);
        rst_i = 1'b0;
        tick();

        // AND of 0xF0F and 0x0FF, with a two-cycle latency check
        push(scale(14'h00F), 3'd1);
        send(5'b00101, 2'b00, 12'hF0F, 12'h123, 12'h0FF, 12'h000, 12'h555, 1'b1);
        chk("lat_n1", out_vld_o, 0);
        tick();
        chk("lat_n2", out_vld_o, 1);
        out_rdy_i = 1'b1;
        tick();
        chk("vld_drop", out_vld_o, 0);

        // Mode table, back-to-back single-voice frames
        push(scale(14'h000), 3'd1);
        send(5'b00000, 2'b01, 12'hABC, 12'hDEF, 12'h123, 12'h456, 12'h789, 1'b1);
        push(scale(14'h000), 3'd1);
        send(5'b00000, 2'b10, 12'hABC, 12'hDEF, 12'h123, 12'h456, 12'h789, 1'b1);
        push(scale(14'h000), 3'd1);
        send(5'b00000, 2'b11, 12'hABC, 12'hDEF, 12'h123, 12'h456, 12'h789, 1'b1);
        push(scale(14'h800), 3'd1);
        send(5'b00111, 2'b11, 12'h123, 12'h800, 12'h7FF, 12'hFFF, 12'hFFF, 1'b1);
        push(scale(14'h0FF), 3'd1);
        send(5'b00011, 2'b01, 12'h0F0, 12'h00F, 12'hF00, 12'hF00, 12'hF00, 1'b1);
        push(scale(14'hF0F), 3'd1);
        send(5'b00011, 2'b10, 12'hFF0, 12'h0FF, 12'h111, 12'h222, 12'h333, 1'b1);
        push(scale(14'h000), 3'd1);
        send(5'b00000, 2'b00, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1);
        repeat (3) tick();

        // Auto-close after four voices without last
        push(scale(14'h3FFC), 3'd4);
        repeat (4) send(5'b00001, 2'b01, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000, 1'b0);
        repeat (3) tick();

        // Frame end in the same cycle the old sample is accepted
        out_rdy_i = 1'b0;
        push(scale(14'h010), 3'd1);
        push(scale(14'h020), 3'd1);
        send(5'b00001, 2'b01, 12'h010, 12'h0, 12'h0, 12'h0, 12'h0, 1'b1);
        tick();
        chk("hold_vld", out_vld_o, 1);
        send(5'b00001, 2'b01, 12'h020, 12'h0, 12'h0, 12'h0, 12'h0, 1'b1);
        out_rdy_i = 1'b1;
        tick();
        chk("coinc_ovf", ovf_o, 0);
        chk("coinc_vld", out_vld_o, 1);
        repeat (2) tick();

        // Overrun: second frame overwrites an unread first
        out_rdy_i = 1'b0;
        push(scale(14'h222), 3'd1);
        send(5'b00001, 2'b01, 12'h111, 12'h0, 12'h0, 12'h0, 12'h0, 1'b1);
        repeat (2) tick();
        chk("pre_ovf", ovf_o, 0);
        send(5'b00001, 2'b01, 12'h222, 12'h0, 12'h0, 12'h0, 12'h0, 1'b1);
        repeat (2) tick();
        chk("ovf_set", ovf_o, 1);
        out_rdy_i = 1'b1;
        repeat (2) tick();
        chk("ovf_sticky", ovf_o, 1);

        // Reset in the middle of a frame
        send(5'b00001, 2'b01, 12'h050, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        send(5'b00001, 2'b01, 12'h060, 12'h0, 12'h0, 12'h0, 12'h0, 1'b0);
        rst_i = 1'b1;
        tick();
        chk("mid_rst_vld", out_vld_o, 0);
        chk("mid_rst_sample", sample_o, 0);
        chk("mid_rst_nvoc", nvoc_o, 0);
        chk("mid_rst_ovf", ovf_o, 0);
        rst_i = 1'b0;
        push(scale(14'h100), 3'd1);
        send(5'b00001, 2'b01, 12'h100, 12'h0, 12'h0, 12'h0, 12'h0, 1'b1);
        repeat (3) tick();

        // Random voices with gaps against the reference model
        acc_m = '0;
        cnt_m = 0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) tick();
            for (int i = 0; i < 5; i++) w[i] = 12'($urandom_range(0, 4095));
            rs = 5'($urandom_range(0, 31));
            rm = 2'($urandom_range(0, 3));
            rl = ($urandom_range(0, 3) == 0);
            acc_m = acc_m + 14'(ref_comb(rs, rm, w));
            cnt_m++;
            if (rl || cnt_m == 4) begin
                push(scale(acc_m), 3'(cnt_m));
                acc_m = '0;
                cnt_m = 0;
            end
            send(rs, rm, w[0], w[1], w[2], w[3], w[4], rl);
        end
        if (cnt_m > 0) begin
            push(scale(acc_m), 3'(cnt_m + 1));
            send(5'b00000, 2'b01, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1);
        end

        for (int i = 0; i < 20 && exp_s.size() > 0; i++) tick();
        if (exp_s.size() > 0) begin
            nvec++;
            nerr++;
            $display("FAIL drain: %0d frames outstanding, expected 0", exp_s.size());
        end
        chk("rand_ovf", ovf_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
